// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Shares the single cache_control valid/ready port between the CPU
//   instruction fetch (i) and data (d) requesters for DRAM-mapped addresses.
//   A grant is locked for the whole transaction. The request is latched into
//   the mem_* registers on grant and held stable until mem_ready. Every
//   completion is followed by one IDLE cycle before the next grant.
//
//   Build option:
//     ARB_RR_EN defined   : round-robin between i and d on conflict.
//     ARB_RR_EN undefined : d has priority. After MAX_DSTREAK consecutive d grants
//                           taken while i was waiting, i is granted once.
//
//   Parameters:
//     ADDR_W       downstream address width (low ADDR_W bits of requester addr)
//     MAX_DSTREAK  max consecutive d grants while i waits (d-priority mode only)
//
//   Ports:
//     clk, resetn                   clock, asynchronous active-low reset
//     i_valid/i_addr                fetch request (held until i_ready)
//     i_ready/i_rdata               fetch completion pulse and data
//     d_valid/d_addr/d_wmask/d_wdata data request (wmask 0 = read)
//     d_ready/d_rdata               data completion pulse and read data
//     mem_valid/addr/wmask/wdata    latched request towards cache_control
//     mem_ready/mem_rdata           completion and read data from cache_control
`timescale 1ns/1ps

module cache_arbiter #(
    parameter int ADDR_W      = 26,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_valid,
    input  logic [31:0]       i_addr,
    output logic              i_ready,
    output logic [31:0]       i_rdata,
    input  logic              d_valid,
    input  logic [31:0]       d_addr,
    input  logic [3:0]        d_wmask,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wmask,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_wmask_q, mem_wmask_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    // Cleared if the granted requester ever drops valid during its access;
    // the access still completes downstream but its ready pulse is suppressed.
    logic              keep_q, keep_d;
    logic              grant_i, grant_d;

    // High address bits are outside the downstream window by construction.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{i_addr, d_addr};

`ifdef ARB_RR_EN
    // 1 = d was served last; reset value means "i served last" so d wins first.
    logic last_d_q, last_d_d;
`else
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
    logic [SW-1:0] streak_q, streak_d;
`endif

    // Arbitration: only evaluated in IDLE.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == IDLE) begin
            if (i_valid && d_valid) begin
`ifdef ARB_RR_EN
                if (last_d_q) grant_i = 1'b1;
                else          grant_d = 1'b1;
`else
                if (streak_q == STREAK_MAX) grant_i = 1'b1;
                else                        grant_d = 1'b1;
`endif
            end else if (i_valid) begin
                grant_i = 1'b1;
            end else if (d_valid) begin
                grant_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wmask_d = mem_wmask_q;
        mem_wdata_d = mem_wdata_q;
        keep_d      = keep_q;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d     = GNT_I;
                    mem_addr_d  = i_addr[ADDR_W-1:0];
                    mem_wmask_d = 4'b0000;
                    mem_wdata_d = 32'h0;
                    keep_d      = 1'b1;
                end else if (grant_d) begin
                    state_d     = GNT_D;
                    mem_addr_d  = d_addr[ADDR_W-1:0];
                    mem_wmask_d = d_wmask;
                    mem_wdata_d = d_wdata;
                    keep_d      = 1'b1;
                end
            end
            GNT_I: begin
                if (!i_valid) keep_d = 1'b0;
                if (mem_ready) state_d = IDLE;
            end
            GNT_D: begin
                if (!d_valid) keep_d = 1'b0;
                if (mem_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ARB_RR_EN
    always_comb begin
        last_d_d = last_d_q;
        if (grant_i) last_d_d = 1'b0;
        if (grant_d) last_d_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) last_d_q <= 1'b0;
        else         last_d_q <= last_d_d;
    end
`else
    // Count d grants taken while i was waiting; any i grant or an
    // uncontended d grant restarts the count.
    always_comb begin
        streak_d = streak_q;
        if (grant_i) begin
            streak_d = '0;
        end else if (grant_d) begin
            if (!i_valid)                     streak_d = '0;
            else if (streak_q != STREAK_MAX)  streak_d = streak_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) streak_q <= '0;
        else         streak_q <= streak_d;
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wmask_q <= 4'b0000;
            mem_wdata_q <= 32'h0;
            keep_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wmask_q <= mem_wmask_d;
            mem_wdata_q <= mem_wdata_d;
            keep_q      <= keep_d;
        end
    end

    // mem_valid is decoded from state so an asynchronous reset drops it at once.
    assign mem_valid = (state_q != IDLE);
    assign mem_addr  = mem_addr_q;
    assign mem_wmask = mem_wmask_q;
    assign mem_wdata = mem_wdata_q;

    // Completion is forwarded combinationally in the mem_ready cycle.
    assign i_ready = (state_q == GNT_I) && mem_ready && keep_q && i_valid;
    assign d_ready = (state_q == GNT_D) && mem_ready && keep_q && d_valid;
    assign i_rdata = i_ready ? mem_rdata : 32'h0;
    assign d_rdata = d_ready ? mem_rdata : 32'h0;

endmodule
